// File: rtl/ff_bank_pkg.sv
// Shared types and helpers for the round-robin register bank arbiter.
// The state enum, default sizes and the one-hot decode live here.
package ff_bank_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_WIDTH = 8;
    localparam int MAX_REQ   = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [MAX_REQ-1:0] onehot(input logic [3:0] idx);
        return MAX_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
// The request vector is doubled so a single upward scan covers the wrap.
module rr_pick
    import ff_bank_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             any,
    output logic [ID_W-1:0]  idx
);

    logic [2*N_REQ-1:0] dbl;
    logic [2*N_REQ-1:0] rot;
    logic               found;
    int                 pos;

    always_comb begin
        dbl   = {req, req};
        rot   = dbl >> ptr;
        any   = |req;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                pos   = int'(ptr) + i;
                if (pos >= N_REQ) pos = pos - N_REQ;
                idx   = ID_W'(pos);
            end
        end
    end

endmodule

// File: rtl/ff_bank_rr_arbiter.sv
// Round-robin arbiter sharing one data register between N_REQ writers.
// One cycle of grant, one cycle of write; ptr advances past each writer.
module ff_bank_rr_arbiter
    import ff_bank_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] data_in,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       q,
    output logic                   q_valid,
    output logic                   wr_pulse,
    output logic [ID_W-1:0]        owner,
    output logic                   busy
);

    state_t            state;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   win;
    logic              pick_any;
    logic [ID_W-1:0]   pick_idx;
    logic [N_REQ-1:0]  gnt_nxt;
    logic [WIDTH-1:0]  sel_data;
    logic [ID_W-1:0]   ptr_nxt;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .any   (pick_any),
        .idx   (pick_idx)
    );

    always_comb begin
        gnt_nxt  = N_REQ'(onehot(4'(pick_idx)));
        sel_data = data_in[int'(win)*WIDTH +: WIDTH];
        ptr_nxt  = (int'(win) == N_REQ-1) ? '0 : win + ID_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            gnt      <= '0;
            q        <= '0;
            q_valid  <= 1'b0;
            wr_pulse <= 1'b0;
            owner    <= '0;
            busy     <= 1'b0;
            ptr      <= '0;
            win      <= '0;
        end else begin
            wr_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        gnt   <= gnt_nxt;
                        busy  <= 1'b1;
                        win   <= pick_idx;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                    // a withdrawn request aborts without touching q/owner/ptr
                    if (req[win]) begin
                        q        <= sel_data;
                        owner    <= win;
                        q_valid  <= 1'b1;
                        wr_pulse <= 1'b1;
                        ptr      <= ptr_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ff_bank_rr_arbiter.md
Name: ff_bank_rr_arbiter

Overview:
- Round-robin arbiter that shares one W-bit D-flip-flop data register between N requesters.
- Grants write access to one requester at a time and captures that requester's data into the register.
- Reports which requester wrote last, plus a one-cycle write strobe.
- Sits between the requesting blocks and the shared register consumers.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- WIDTH, 8, data width of each requester and of the shared register.
- ID_W, $clog2(N_REQ), width of the owner id (derived; do not override).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted, 1 = run).
- req  input  N_REQ  level request, one bit per requester.
- data_in  input  N_REQ*WIDTH  requester data; requester i occupies bits [i*WIDTH +: WIDTH].
- gnt  output  N_REQ  registered one-hot grant; all zero when no grant is active.
- q  output  WIDTH  shared data register.
- q_valid  output  1  sticky; 1 once any write has completed since reset.
- wr_pulse  output  1  high for exactly one cycle after each completed write.
- owner  output  ID_W  index of the requester that performed the last write.
- busy  output  1  high while in GRANT.

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately): gnt=0, q=0, q_valid=0, wr_pulse=0, owner=0, busy=0, ptr=0, state=IDLE.
- A reset mid-grant aborts the transfer with no write.
- FSM states: IDLE and GRANT.
- IDLE with req==0: stay in IDLE.
- IDLE with req!=0:
  - Pick the winner w = first set bit of req, searching upward from ptr and wrapping modulo N_REQ.
  - Next edge: gnt=onehot(w), busy=1, state=GRANT, win register=w.
- GRANT with req[w]==1:
  - Next edge: q=data_in[w], owner=w, q_valid=1, wr_pulse=1, ptr=(w+1) mod N_REQ, gnt=0, busy=0, state=IDLE.
- GRANT with req[w]==0 (requester withdrew):
  - Next edge: abort. gnt=0, state=IDLE; q, owner and ptr unchanged; no wr_pulse.
- wr_pulse is deasserted on every edge where no write occurs.
- Latency: req seen in cycle k -> gnt in cycle k+1 -> q, owner and wr_pulse updated in cycle k+2.
- Throughput: at most one write every 2 cycles. The IDLE in cycle k+2 can issue the next grant for cycle k+3.
- A requester that keeps req high after its write is treated as a new request. Because ptr has advanced past it, every other pending requester is served first.
- Starvation bound: a continuously requesting requester is granted within N_REQ arbitration rounds.
- ptr wraps: a write by requester N_REQ-1 sets ptr=0.
- Requests changing while in GRANT do not affect the current grant; they are evaluated in the next IDLE.
- data_in is sampled only at the GRANT->IDLE edge; data_in of non-granted requesters is ignored.
- gnt is never multi-hot; at most one requester is granted at any time.

Decomposition:
- Package ff_bank_pkg:
  - state enum {IDLE, GRANT};
  - the one-hot helper function;
  - default constants for N_REQ and WIDTH.
- Sub-module rr_pick (purely combinational):
  - inputs req and ptr; outputs any and idx.
  - Implemented as a doubled-vector priority search.
  - Instantiated once; testable standalone.

Test Plan:
1. Reset/idle: hold rst=0 with random req -> all outputs 0. Release rst with req=0 for 5 cycles -> outputs stay 0, busy=0.
2. Single write: req=4'b0100, data_in[2]=8'hA5 -> gnt=4'b0100 for 1 cycle, then q=8'hA5, owner=2, wr_pulse=1 for 1 cycle, q_valid=1, ptr=3.
3. Round-robin fairness: req=4'b1111 held with data_in[i]=8'h10+i -> writes in order 0,1,2,3,0,... Each wr_pulse is 2 cycles apart; q sequence 10,11,12,13,10.
4. Wrap and skip: ptr=3 after a write by requester 2; req=4'b0011 -> requester 0 granted first, then requester 1.
5. Withdrawal: requester 1 granted, req[1] dropped during GRANT -> no wr_pulse, q and owner unchanged, next grant goes to the next pending requester from the unchanged ptr.
6. Async reset mid-grant: drive rst=0 between clock edges while gnt=4'b0010 -> gnt=0 and q=0 immediately, with no wr_pulse after release.
